cdu_count_scheduler: RTL and testbench
======================================

Name: cdu_count_scheduler

Overview:
- Shares the single AGC counter-increment interface between the three CDU channels (A, B, C).
- Each channel's read counter produces unit up/down level pulses; this block accumulates each channel's net backlog in a saturating signed counter.
- It grants channels round-robin and issues one increment or decrement per request/acknowledge handshake, with a programmable minimum gap between requests.
- Sits between the per-channel read counters and the AGC counter cells.

Parameters:
- BW, 4: backlog counter width, two's complement; range -2^(BW-1)..2^(BW-1)-1.
- GAP, 3: idle cycles enforced after each acknowledge before the next request may rise (0 allowed).

Ports:
- CLOCKH  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- AUPLVL  in  1  channel A +1 count pulse (one CLOCKH cycle wide).
- ADNLVL  in  1  channel A -1 count pulse.
- BUPLVL  in  1  channel B +1 count pulse.
- BDNLVL  in  1  channel B -1 count pulse.
- CUPLVL  in  1  channel C +1 count pulse.
- CDNLVL  in  1  channel C -1 count pulse.
- ACDUZ  in  1  zero channel A backlog and overflow flag (level).
- BCDUZ  in  1  zero channel B backlog and overflow flag.
- CCDUZ  in  1  zero channel C backlog and overflow flag.
- CNTEN  in  1  AGC counting enable; when low, no new request is raised.
- CNTACK  in  1  AGC acknowledge of the current request (one cycle).
- CNTREQ  out  1  request to AGC counter interface.
- CNTCH  out  2  granted channel: 0=A, 1=B, 2=C; 3 never driven.
- CNTDIR  out  1  1 = increment (+), 0 = decrement (-).
- OVF  out  3  sticky per-channel backlog saturation flags, bit0=A.
- BUSY  out  1  high when any backlog is nonzero or FSM is not IDLE.

Behaviour:
- Reset (async, rst_n low): all backlogs = 0, OVF = 0, CNTREQ = 0, CNTCH = 0, CNTDIR = 0, BUSY = 0, FSM = IDLE, round-robin pointer = A.
- Backlog update per channel each edge: delta = UP - DN - (ack on this channel ? sign(backlog) : 0).
  - UP and DN in the same cycle cancel.
  - Result saturates at the range limits. Any saturation clip sets that channel's OVF bit (sticky).
  - xCDUZ high forces backlog to 0 and clears that OVF bit, overriding all deltas.
- FSM states:
  - IDLE: if CNTEN = 1 and any backlog != 0, select the first nonzero channel at or after the pointer (order A->B->C->A).
    - Next edge: CNTREQ = 1, CNTCH = that channel, CNTDIR = (backlog > 0). Go to REQ.
  - REQ: CNTREQ, CNTCH and CNTDIR are held stable until CNTACK; they are never withdrawn, even if CNTEN falls or xCDUZ clears the granted backlog.
    - On CNTACK edge: CNTREQ = 0; backlog of CNTCH moves one step toward zero, or is untouched if it is already 0 or its CDUZ is high; pointer = CNTCH + 1 mod 3.
    - Go to GAP, or to IDLE if GAP = 0.
  - GAP: count GAP edges, then go to IDLE. CNTACK here is ignored.
- Latency: a pulse sampled at edge k updates the backlog at k. If the FSM is IDLE at k, CNTREQ rises at edge k+1.
- Throughput: with immediate ack and GAP = g, at most one count per g+2 cycles.
- Direction flip: if the granted backlog changes sign while in REQ, the ack still steps toward zero from the current value. CNTDIR reflects the sign at grant only.
- BUSY is combinational from the registered state.

Test Plan:
- Reset with all inputs 0: outputs all 0. Three AUPLVL pulses, ack 1 cycle after each REQ, GAP=3 -> three requests with CNTCH=0, CNTDIR=1, spaced 5 cycles; backlog A returns to 0; BUSY falls after the final GAP.
- A=+2, B=-1, C=+1 loaded while CNTEN=0 -> no CNTREQ. Raise CNTEN -> grant order A(+), B(-), C(+), A(+), then idle.
- 10 BUPLVL pulses with CNTEN=0, BW=4 -> backlog B=7, OVF=3'b010. Pulse BCDUZ -> backlog 0, OVF=0.
- AUPLVL and ADNLVL in the same cycle -> backlog A unchanged; no request raised.
- Grant channel C (backlog +1), assert CCDUZ during REQ with ack delayed 4 cycles -> CNTREQ held for 4 cycles; after ack, backlog C = 0 (not -1).
- Assert rst_n low mid-REQ -> CNTREQ = 0 immediately (asynchronous); after release, FSM is IDLE and all backlogs are 0.

Source files
------------

// File: rtl/cdu_count_scheduler.sv
// Arbitrates the three CDU channels onto the single AGC counter-increment port,
// keeping a saturating signed backlog per channel and issuing one step per handshake.
module cdu_count_scheduler #(
   parameter int BW  = 4,
   parameter int GAP = 3
) (
   input  logic       CLOCKH,
   input  logic       rst_n,
   input  logic       AUPLVL,
   input  logic       ADNLVL,
   input  logic       BUPLVL,
   input  logic       BDNLVL,
   input  logic       CUPLVL,
   input  logic       CDNLVL,
   input  logic       ACDUZ,
   input  logic       BCDUZ,
   input  logic       CCDUZ,
   input  logic       CNTEN,
   input  logic       CNTACK,
   output logic       CNTREQ,
   output logic [1:0] CNTCH,
   output logic       CNTDIR,
   output logic [2:0] OVF,
   output logic       BUSY
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam int MAX_V = 2 ** (BW - 1) - 1;
   localparam int MIN_V = -(2 ** (BW - 1));

   state_t               state;
   state_t               state_next;
   logic signed [BW-1:0] backlog      [3];
   logic signed [BW-1:0] backlog_next [3];
   logic [2:0]           ovf_next;
   logic [2:0]           up;
   logic [2:0]           dn;
   logic [2:0]           zero;
   logic [2:0]           nz;
   logic [1:0]           ptr;
   logic [1:0]           ptr_next;
   logic [1:0]           ch_next;
   logic [1:0]           sel;
   logic                 sel_found;
   logic                 dir_next;
   logic                 ack_hit;
   logic [GW-1:0]        gap_cnt;
   logic [GW-1:0]        gap_next;

   assign up      = {CUPLVL, BUPLVL, AUPLVL};
   assign dn      = {CDNLVL, BDNLVL, ADNLVL};
   assign zero    = {CCDUZ, BCDUZ, ACDUZ};
   assign ack_hit = (state == S_REQ) && CNTACK;
   assign CNTREQ  = (state == S_REQ);
   assign BUSY    = (state != S_IDLE) || (nz != 3'b000);

   always_comb begin
      for (int c = 0; c < 3; c++) begin
         nz[c] = (backlog[c] != '0);
      end
   end

   // An acknowledge steps the granted backlog one unit toward zero from its current value.
   always_comb begin
      int sum;
      ovf_next = OVF;
      sum      = 0;
      for (int c = 0; c < 3; c++) begin
         sum = int'(backlog[c]) + int'(up[c]) - int'(dn[c]);
         if (ack_hit && (CNTCH == 2'(c))) begin
            if (backlog[c] > 0) begin
               sum = sum - 1;
            end else if (backlog[c] < 0) begin
               sum = sum + 1;
            end
         end
         if (zero[c]) begin
            backlog_next[c] = '0;
            ovf_next[c]     = 1'b0;
         end else if (sum > MAX_V) begin
            backlog_next[c] = BW'(MAX_V);
            ovf_next[c]     = 1'b1;
         end else if (sum < MIN_V) begin
            backlog_next[c] = BW'(MIN_V);
            ovf_next[c]     = 1'b1;
         end else begin
            backlog_next[c] = BW'(sum);
         end
      end
   end

   // Round-robin search: first nonzero channel at or after the pointer.
   always_comb begin
      int idx;
      sel       = ptr;
      sel_found = 1'b0;
      idx       = 0;
      for (int i = 0; i < 3; i++) begin
         idx = int'(ptr) + i;
         if (idx > 2) begin
            idx = idx - 3;
         end
         if (!sel_found && nz[2'(idx)]) begin
            sel_found = 1'b1;
            sel       = 2'(idx);
         end
      end
   end

   always_comb begin
      state_next = state;
      ch_next    = CNTCH;
      dir_next   = CNTDIR;
      ptr_next   = ptr;
      gap_next   = gap_cnt;
      case (state)
         S_IDLE: begin
            if (CNTEN && sel_found) begin
               state_next = S_REQ;
               ch_next    = sel;
               dir_next   = (backlog[sel] > 0);
            end
         end
         S_REQ: begin
            if (CNTACK) begin
               ptr_next   = (CNTCH == 2'd2) ? 2'd0 : CNTCH + 2'd1;
               gap_next   = '0;
               state_next = (GAP == 0) ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_next = S_IDLE;
            end else begin
               gap_next = gap_cnt + 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCKH or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ptr     <= 2'd0;
         CNTCH   <= 2'd0;
         CNTDIR  <= 1'b0;
         gap_cnt <= '0;
      end else begin
         state   <= state_next;
         ptr     <= ptr_next;
         CNTCH   <= ch_next;
         CNTDIR  <= dir_next;
         gap_cnt <= gap_next;
      end
   end

   always_ff @(posedge CLOCKH or negedge rst_n) begin
      if (!rst_n) begin
         OVF <= 3'b000;
         for (int c = 0; c < 3; c++) begin
            backlog[c] <= '0;
         end
      end else begin
         OVF <= ovf_next;
         for (int c = 0; c < 3; c++) begin
            backlog[c] <= backlog_next[c];
         end
      end
   end

endmodule

// File: tb/tb_cdu_count_scheduler.sv
// Randomized and directed bench for cdu_count_scheduler; a queue of predicted grants
// from an arithmetic reference model is drained by an independent output monitor.
module tb_cdu_count_scheduler;

   localparam int BW    = 4;
   localparam int GAP   = 3;
   localparam int MAX_V = 7;
   localparam int MIN_V = -8;

   logic       clk;
   logic       rst_n = 1'b0;
   logic [2:0] up = 3'b000;
   logic [2:0] dn = 3'b000;
   logic [2:0] cduz = 3'b000;
   logic       cnt_en = 1'b0;
   logic       cnt_ack = 1'b0;
   logic       cnt_req;
   logic [1:0] cnt_ch;
   logic       cnt_dir;
   logic [2:0] ovf;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cycle = 0;

   logic [2:0] exp_q[$];
   logic [2:0] grant_log[$];
   int         rise_log[$];
   logic       prev_req = 1'b0;

   int         fixed_delay = 0;
   bit         rand_ack = 1'b0;
   int         cur_delay = 0;
   int         wait_cnt = 0;

   int         m_bl [3] = '{0, 0, 0};
   bit [2:0]   m_ovf = 3'b000;
   int         m_mode = 0;
   int         m_gap_left = 0;
   int         m_ptr = 0;
   int         m_ch = 0;
   bit         m_dir = 1'b0;

   cdu_count_scheduler #(.BW(BW), .GAP(GAP)) dut (
      .CLOCKH(clk),
      .rst_n (rst_n),
      .AUPLVL(up[0]),
      .ADNLVL(dn[0]),
      .BUPLVL(up[1]),
      .BDNLVL(dn[1]),
      .CUPLVL(up[2]),
      .CDNLVL(dn[2]),
      .ACDUZ (cduz[0]),
      .BCDUZ (cduz[1]),
      .CCDUZ (cduz[2]),
      .CNTEN (cnt_en),
      .CNTACK(cnt_ack),
      .CNTREQ(cnt_req),
      .CNTCH (cnt_ch),
      .CNTDIR(cnt_dir),
      .OVF   (ovf),
      .BUSY  (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle++;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic bit m_busy();
      return (m_bl[0] != 0) || (m_bl[1] != 0) || (m_bl[2] != 0) || (m_mode != 0);
   endfunction

   // Reference model: mode 0 idle, 1 request outstanding, 2 post-acknowledge gap.
   always @(posedge clk or negedge rst_n) begin : model
      int  old_bl [3];
      int  v;
      int  c;
      bit  found;
      bit  ack_hit;
      int  ack_ch;
      if (!rst_n) begin
         m_bl   = '{0, 0, 0};
         m_ovf  = 3'b000;
         m_mode = 0;
         m_ptr  = 0;
         m_ch   = 0;
         m_dir  = 1'b0;
         exp_q.delete();
      end else begin
         old_bl  = m_bl;
         ack_hit = (m_mode == 1) && cnt_ack;
         ack_ch  = m_ch;
         found   = 1'b0;
         if (m_mode == 0) begin
            if (cnt_en) begin
               for (int i = 0; i < 3; i++) begin
                  c = (m_ptr + i) % 3;
                  if (!found && old_bl[c] != 0) begin
                     found  = 1'b1;
                     m_ch   = c;
                     m_dir  = old_bl[c] > 0;
                     m_mode = 1;
                     exp_q.push_back({2'(c), m_dir});
                  end
               end
            end
         end else if (m_mode == 1) begin
            if (cnt_ack) begin
               m_ptr = (m_ch + 1) % 3;
               if (GAP > 0) begin
                  m_mode     = 2;
                  m_gap_left = GAP;
               end else begin
                  m_mode = 0;
               end
            end
         end else begin
            m_gap_left--;
            if (m_gap_left == 0) m_mode = 0;
         end
         for (int k = 0; k < 3; k++) begin
            v = old_bl[k] + int'(up[k]) - int'(dn[k]);
            if (ack_hit && ack_ch == k) begin
               if (old_bl[k] > 0) v = v - 1;
               else if (old_bl[k] < 0) v = v + 1;
            end
            if (v > MAX_V) begin
               v = MAX_V;
               m_ovf[k] = 1'b1;
            end
            if (v < MIN_V) begin
               v = MIN_V;
               m_ovf[k] = 1'b1;
            end
            if (cduz[k]) begin
               v = 0;
               m_ovf[k] = 1'b0;
            end
            m_bl[k] = v;
         end
      end
   end

   always @(negedge clk) begin : monitor
      logic [2:0] got;
      check_output("req", cnt_req, m_mode == 1);
      check_output("ovf", ovf, m_ovf);
      check_output("busy", busy, m_busy());
      if (cnt_req && !prev_req) begin
         got = {cnt_ch, cnt_dir};
         grant_log.push_back(got);
         rise_log.push_back(cycle);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_unexpected actual=%0h expected=none", got);
         end else begin
            check_output("grant", got, exp_q.pop_front());
         end
      end
      if (cnt_req && m_mode == 1) begin
         check_output("hold_ch", cnt_ch, m_ch);
         check_output("hold_dir", cnt_dir, m_dir);
      end
      prev_req = cnt_req;
   end

   always @(negedge clk) begin : responder
      if (cnt_ack) begin
         cnt_ack = 1'b0;
      end else if (!cnt_req) begin
         wait_cnt  = 0;
         cur_delay = rand_ack ? int'($urandom_range(0, 3)) : fixed_delay;
      end else if (wait_cnt >= cur_delay) begin
         cnt_ack  = 1'b1;
         wait_cnt = 0;
      end else begin
         wait_cnt++;
      end
   end

   task automatic apply_stimulus(input logic [2:0] u, input logic [2:0] d, input logic [2:0] z);
      up   = u;
      dn   = d;
      cduz = z;
      @(negedge clk);
      up   = 3'b000;
      dn   = 3'b000;
      cduz = 3'b000;
   endtask

   task automatic apply_reset();
      rst_n  = 1'b0;
      cnt_en = 1'b0;
      up     = 3'b000;
      dn     = 3'b000;
      cduz   = 3'b000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n = 0;
      while ((busy || cnt_req) && n < limit) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= limit) begin
         errors++;
         $display("[TB] FAIL %s actual=busy expected=idle", name);
      end
   endtask

   task automatic wait_req(input string name, input int limit);
      int n = 0;
      while (!cnt_req && n < limit) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= limit) begin
         errors++;
         $display("[TB] FAIL %s actual=no_request expected=request", name);
      end
   endtask

   initial begin
      int         base;
      int         pu;
      int         pd;
      logic [2:0] exp_order [4];
      exp_order = '{3'b001, 3'b010, 3'b101, 3'b001};

      $display("[TB] reset state");
      repeat (2) @(negedge clk);
      check_output("rst_req", cnt_req, 0);
      check_output("rst_ch", cnt_ch, 0);
      check_output("rst_dir", cnt_dir, 0);
      check_output("rst_ovf", ovf, 0);
      check_output("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] three A pulses, immediate ack");
      fixed_delay = 0;
      cnt_en      = 1'b1;
      base        = rise_log.size();
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(3'b001, 3'b000, 3'b000);
         @(negedge clk);
      end
      wait_idle("t1_idle", 100);
      check_output("t1_count", rise_log.size() - base, 3);
      if (rise_log.size() - base == 3) begin
         check_output("t1_space1", rise_log[base+1] - rise_log[base], 5);
         check_output("t1_space2", rise_log[base+2] - rise_log[base+1], 5);
      end
      check_output("t1_ch_dir", grant_log[grant_log.size()-1], 3'b001);

      $display("[TB] load with counting disabled, then grant order");
      apply_reset();
      apply_stimulus(3'b101, 3'b010, 3'b000);
      apply_stimulus(3'b001, 3'b000, 3'b000);
      base = grant_log.size();
      repeat (5) @(negedge clk);
      check_output("t2_no_req", grant_log.size() - base, 0);
      check_output("t2_busy", busy, 1);
      cnt_en = 1'b1;
      wait_idle("t2_idle", 100);
      check_output("t2_count", grant_log.size() - base, 4);
      if (grant_log.size() - base == 4) begin
         for (int i = 0; i < 4; i++) check_output("t2_order", grant_log[base+i], exp_order[i]);
      end

      $display("[TB] saturation and zeroing");
      apply_reset();
      for (int i = 0; i < 10; i++) apply_stimulus(3'b010, 3'b000, 3'b000);
      check_output("t3_ovf", ovf, 3'b010);
      apply_stimulus(3'b000, 3'b000, 3'b010);
      check_output("t3_ovf_clr", ovf, 3'b000);
      check_output("t3_busy", busy, 0);

      $display("[TB] cancelling up and down");
      apply_reset();
      cnt_en = 1'b1;
      base   = grant_log.size();
      apply_stimulus(3'b001, 3'b001, 3'b000);
      repeat (3) @(negedge clk);
      check_output("t4_no_req", grant_log.size() - base, 0);
      check_output("t4_busy", busy, 0);

      $display("[TB] zeroing the granted channel during a request");
      apply_reset();
      fixed_delay = 4;
      cnt_en      = 1'b1;
      base        = grant_log.size();
      apply_stimulus(3'b100, 3'b000, 3'b000);
      wait_req("t5_req", 10);
      apply_stimulus(3'b000, 3'b000, 3'b100);
      check_output("t5_held", cnt_req, 1);
      wait_idle("t5_idle", 50);
      check_output("t5_count", grant_log.size() - base, 1);
      check_output("t5_grant", grant_log[grant_log.size()-1], 3'b101);
      repeat (3) @(negedge clk);
      check_output("t5_busy", busy, 0);

      $display("[TB] asynchronous reset during a request");
      apply_reset();
      fixed_delay = 3;
      cnt_en      = 1'b1;
      apply_stimulus(3'b011, 3'b000, 3'b000);
      wait_req("t6_req", 10);
      #2 rst_n = 1'b0;
      #1;
      check_output("t6_async_req", cnt_req, 0);
      check_output("t6_async_busy", busy, 0);
      check_output("t6_async_ch", cnt_ch, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_output("t6_after_req", cnt_req, 0);
      check_output("t6_after_busy", busy, 0);

      $display("[TB] random traffic");
      apply_reset();
      rand_ack = 1'b1;
      for (int seg = 0; seg < 15; seg++) begin
         pu     = int'($urandom_range(0, 40));
         pd     = int'($urandom_range(0, 40));
         cnt_en = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 200; k++) begin
            for (int c = 0; c < 3; c++) begin
               up[c]   = (int'($urandom_range(0, 99)) < pu);
               dn[c]   = (int'($urandom_range(0, 99)) < pd);
               cduz[c] = ($urandom_range(0, 299) == 0);
            end
            @(negedge clk);
         end
      end
      up     = 3'b000;
      dn     = 3'b000;
      cduz   = 3'b000;
      cnt_en = 1'b1;
      wait_idle("rand_drain", 1000);
      check_output("queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
